// File: rtl/key_bounce_gen.sv
// Mechanical key waveform generator: drives an active-low tap line through
// falling bounce, clean hold, rising bounce and release, timed by a tick enable.
module key_bounce_gen #(
  parameter int unsigned TICK_DIV     = 50_000,
  parameter int unsigned BOUNCE_TICKS = 8,
  parameter int unsigned GLITCH_W     = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_hold,
  input  logic        cmd_bounce,
  output logic        tap,
  output logic        busy,
  output logic        done
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_W  = $clog2(BOUNCE_TICKS + 1);
  localparam int IV_W  = GLITCH_W + 1;
  localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BOUNCE_TICKS);

  typedef enum logic [2:0] {IDLE, FALL_B, HOLD, RISE_B, DONE} state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [15:0]       hold_cnt_q, hold_cnt_d;
  logic [IV_W-1:0]   ivl_q, ivl_d;
  logic [15:0]       hold_r_q, hold_r_d;
  logic              bounce_r_q, bounce_r_d;
  logic              tap_q, tap_d;

  logic              tick;
  logic              accept;
  logic              lfsr_fb;
  logic [IV_W-1:0]   ivl_load;
  logic [IV_W-1:0]   ivl_dec;
  logic [PH_W-1:0]   phase_inc;
  logic [15:0]       hold_inc;

  assign tick      = (presc_q == PRE_LAST);
  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign tap       = tap_q;

  // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign ivl_load  = IV_W'(lfsr_q[GLITCH_W-1:0]) + IV_W'(1);
  assign ivl_dec   = ivl_q - IV_W'(1);
  assign phase_inc = phase_q + PH_W'(1);
  assign hold_inc  = hold_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    phase_d    = phase_q;
    ivl_d      = ivl_q;
    hold_cnt_d = hold_cnt_q;
    hold_r_d   = hold_r_q;
    bounce_r_d = bounce_r_q;
    lfsr_d     = tick ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;

    case (state_q)
      IDLE: begin
        tap_d = 1'b1;
        if (accept) begin
          hold_r_d   = (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
          bounce_r_d = cmd_bounce;
          tap_d      = 1'b0;
          hold_cnt_d = '0;
          phase_d    = '0;
          ivl_d      = ivl_load;
          state_d    = cmd_bounce ? FALL_B : HOLD;
        end
      end
      FALL_B, RISE_B: begin
        if (tick) begin
          phase_d = phase_inc;
          ivl_d   = ivl_dec;
          // Phase end wins over a toggle falling due on the same tick
          if (phase_inc == PH_LAST) begin
            tap_d      = (state_q == RISE_B);
            hold_cnt_d = '0;
            state_d    = (state_q == FALL_B) ? HOLD : DONE;
          end else if (ivl_dec == '0) begin
            tap_d = ~tap_q;
            ivl_d = ivl_load;
          end
        end
      end
      HOLD: begin
        tap_d = 1'b0;
        if (tick) begin
          hold_cnt_d = hold_inc;
          if (hold_inc == hold_r_q) begin
            tap_d   = 1'b1;
            phase_d = '0;
            ivl_d   = ivl_load;
            state_d = bounce_r_q ? RISE_B : DONE;
          end
        end
      end
      DONE: begin
        tap_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        tap_d   = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Restarting the prescaler on every transition keeps phases tick-aligned
    if ((state_d != state_q) || tick) presc_d = '0;
    else                              presc_d = presc_q + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      lfsr_q     <= SEED;
      phase_q    <= '0;
      hold_cnt_q <= '0;
      ivl_q      <= '0;
      hold_r_q   <= '0;
      bounce_r_q <= 1'b0;
      tap_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      lfsr_q     <= lfsr_d;
      phase_q    <= phase_d;
      hold_cnt_q <= hold_cnt_d;
      ivl_q      <= ivl_d;
      hold_r_q   <= hold_r_d;
      bounce_r_q <= bounce_r_d;
      tap_q      <= tap_d;
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Scoreboarded bench for key_bounce_gen: a reference waveform generator queues
// one expected {tap,cmd_ready,busy,done} record per cycle; a monitor pops and compares.
module tb_key_bounce_gen;

  localparam int TD = 4;
  localparam int BT = 8;
  localparam int GW = 2;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_hold;
  logic        cmd_bounce;
  logic        tap;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [3:0]  exp_q [$];
  logic [15:0] m_lfsr;
  int          m_presc;
  logic [15:0] skip;

  logic cap_tap  [0:127];
  logic cap_done [0:127];
  logic cap_busy [0:127];

  key_bounce_gen #(
    .TICK_DIV(TD), .BOUNCE_TICKS(BT), .GLITCH_W(GW), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_hold(cmd_hold), .cmd_bounce(cmd_bounce), .tap(tap), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic void pushCycles(input int n, input logic [3:0] rec);
    for (int c = 0; c < n; c++) exp_q.push_back(rec);
  endfunction

  // One bounce phase: BT ticks, toggling whenever the glitch interval runs out
  function automatic void bouncePhase(inout logic [15:0] lf, inout logic t, inout int ivl,
                                      input logic endval);
    for (int k = 1; k <= BT; k++) begin
      pushCycles(TD, {t, 3'b010});
      if (k == BT) t = endval;
      else begin
        ivl--;
        if (ivl == 0) begin
          t   = ~t;
          ivl = int'(lf[GW-1:0]) + 1;
        end
      end
      lf = lfsrStep(lf);
    end
  endfunction

  // Queues every cycle of a sequence plus the first idle cycle; returns {lfsr, length}
  function automatic logic [31:0] genSequence(input logic [15:0] lf_in, input int presc,
                                              input logic [15:0] hold_in, input logic bnc);
    logic [15:0] lf;
    logic        t;
    int          ivl;
    int          hold;
    int          len;
    lf   = lf_in;
    t    = 1'b0;
    ivl  = int'(lf[GW-1:0]) + 1;
    hold = (hold_in == 16'd0) ? 1 : int'(hold_in);
    len  = hold * TD + 1 + (bnc ? 2 * BT * TD : 0);
    if (presc == TD - 1) lf = lfsrStep(lf);
    if (bnc) bouncePhase(lf, t, ivl, 1'b0);
    for (int k = 1; k <= hold; k++) begin
      pushCycles(TD, 4'b0010);
      if (k == hold) ivl = int'(lf[GW-1:0]) + 1;
      lf = lfsrStep(lf);
    end
    t = 1'b1;
    if (bnc) bouncePhase(lf, t, ivl, 1'b1);
    pushCycles(1, 4'b1011);
    pushCycles(1, 4'b1100);
    return {lf, len[15:0]};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
      m_lfsr  <= 16'hACE1;
      m_presc <= 0;
      skip    <= '0;
    end else if (skip != 16'd0) begin
      skip <= skip - 16'd1;
    end else if (cmd_valid) begin
      {m_lfsr, skip} <= genSequence(m_lfsr, m_presc, cmd_hold, cmd_bounce);
      m_presc        <= 0;
    end else begin
      exp_q.push_back(4'b1100);
      if (m_presc == TD - 1) begin
        m_lfsr  <= lfsrStep(m_lfsr);
        m_presc <= 0;
      end else begin
        m_presc <= m_presc + 1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rstn) begin
      checkOutput("reset_outputs", {28'd0, tap, cmd_ready, busy, done}, 32'hC);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: no expected record, got %b at t=%0t",
               {tap, cmd_ready, busy, done}, $time);
    end else begin
      checkOutput("cycle_outputs", {28'd0, tap, cmd_ready, busy, done},
                  {28'd0, exp_q.pop_front()});
    end
  end

  task automatic applyStimulus(input logic [15:0] hold, input logic bnc);
    @(negedge clk);
    checkOutput("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_hold   = hold;
    cmd_bounce = bnc;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #2;
  endtask

  // Records cycles 1..n after accept; optionally scrambles the command inputs
  task automatic capture(input int n, input bit keep_valid, input int pulse_at);
    for (int i = 1; i <= n; i++) begin
      cap_tap[i]  = tap;
      cap_done[i] = done;
      cap_busy[i] = busy;
      if (i < n) begin
        @(negedge clk);
        cmd_valid = keep_valid || (i == pulse_at);
        if (i == 1 && !keep_valid) begin
          cmd_hold   = ~cmd_hold;
          cmd_bounce = ~cmd_bounce;
        end
        @(posedge clk);
        #2;
      end
    end
  endtask

  function automatic int countLow(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap_tap[i] == 1'b0) n++;
    return n;
  endfunction

  function automatic int countDone(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap_done[i]) n++;
    return n;
  endfunction

  function automatic int countBusy(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap_busy[i]) n++;
    return n;
  endfunction

  function automatic int spacingViolations(input int lo, input int hi, input logic prev_in);
    int   viol = 0;
    int   last = 0;
    logic prev = prev_in;
    for (int i = lo; i <= hi; i++) begin
      if (cap_tap[i] != prev) begin
        if (last != 0 && ((i - last) < TD || (i - last) > 4 * TD)) viol++;
        last = i;
        prev = cap_tap[i];
      end
    end
    return viol;
  endfunction

  initial begin
    rstn       = 1'b0;
    cmd_valid  = 1'b0;
    cmd_hold   = 16'd0;
    cmd_bounce = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("lfsr_seed", {16'd0, dut.lfsr_q}, 32'hACE1);
    checkOutput("idle_tap", {31'd0, tap}, 32'd1);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(posedge clk);

    $display("[TB] clean press, hold=5, with a command pulse during busy");
    applyStimulus(16'd5, 1'b0);
    capture(22, 1'b0, 8);
    checkOutput("a_low_cycles", countLow(1, 22), 20);
    checkOutput("a_first_low", {31'd0, cap_tap[1]}, 32'd0);
    checkOutput("a_last_low", {31'd0, cap_tap[20]}, 32'd0);
    checkOutput("a_done_at_21", {31'd0, cap_done[21]}, 32'd1);
    checkOutput("a_done_count", countDone(1, 22), 1);
    checkOutput("a_busy_span", countBusy(1, 22), 21);
    repeat (12) @(posedge clk);

    $display("[TB] bouncing press, hold=3");
    applyStimulus(16'd3, 1'b1);
    capture(78, 1'b0, -1);
    checkOutput("b_hold_low", countLow(33, 44), 12);
    checkOutput("b_fall_exit_low", {31'd0, cap_tap[33]}, 32'd0);
    checkOutput("b_rise_entry_high", {31'd0, cap_tap[45]}, 32'd1);
    checkOutput("b_done_at_77", {31'd0, cap_done[77]}, 32'd1);
    checkOutput("b_done_count", countDone(1, 78), 1);
    checkOutput("b_busy_span", countBusy(1, 78), 77);
    checkOutput("b_fall_spacing", spacingViolations(1, 33, 1'b1), 0);
    checkOutput("b_rise_spacing", spacingViolations(45, 77, 1'b0), 0);
    repeat (7) @(posedge clk);

    $display("[TB] zero hold treated as one tick");
    applyStimulus(16'd0, 1'b0);
    capture(6, 1'b0, -1);
    checkOutput("c_low_cycles", countLow(1, 6), 4);
    checkOutput("c_done_at_5", {31'd0, cap_done[5]}, 32'd1);
    repeat (3) @(posedge clk);

    $display("[TB] cmd_valid held high across two sequences");
    applyStimulus(16'd1, 1'b0);
    capture(12, 1'b1, -1);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("d_done_count", countDone(1, 12), 2);
    checkOutput("d_done_at_11", {31'd0, cap_done[11]}, 32'd1);
    checkOutput("d_idle_gap", {31'd0, cap_busy[6]}, 32'd0);
    checkOutput("d_second_low", {31'd0, cap_tap[7]}, 32'd0);
    repeat (6) @(posedge clk);

    $display("[TB] reset asserted during hold");
    applyStimulus(16'd5, 1'b0);
    capture(8, 1'b0, -1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("e_async_tap", {31'd0, tap}, 32'd1);
    checkOutput("e_async_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      checkOutput("e_no_done_in_reset", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(16'd2, 1'b1);
    capture(74, 1'b0, -1);
    checkOutput("e_done_at_73", {31'd0, cap_done[73]}, 32'd1);
    checkOutput("e_busy_span", countBusy(1, 74), 73);
    checkOutput("e_hold_low", countLow(33, 40), 8);

    repeat (6) @(posedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
